// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_wb_pkg;

  // Destination forced for link (jal) writes unless the top overrides it.
  localparam int LINK_REG_DEF = 31;

  // Register address width for a given register count (never below 1 bit).
  function automatic int reg_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  // Which source owns the write port in a given cycle.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_MW,
    WB_MD_Q,
    WB_MD_BYP
  } wb_src_e;

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Bundle of all writeback, mult/div, scoreboard-lookup and register-file write signals.
// Latency: n/a (wires only).
// Backpressure: md_ready throttles md_valid; the MW side has no backpressure.
// Modports: master = pipeline side (drives MW/MD/FD inputs), slave = arbiter.
interface regfile_writeback_arbiter_if
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
);
  localparam int REG_AW = reg_aw(NREGS);

  logic              mw_we;
  logic              mw_link;
  logic [REG_AW-1:0] mw_rd;
  logic [DATA_W-1:0] mw_data;

  logic              md_issue;
  logic [REG_AW-1:0] md_issue_rd;
  logic              md_valid;
  logic [REG_AW-1:0] md_rd;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;

  logic [REG_AW-1:0] fd_rs_a;
  logic [REG_AW-1:0] fd_rs_b;
  logic [REG_AW-1:0] fd_rd;
  logic              busy_a;
  logic              busy_b;
  logic              busy_d;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              proto_err;

  modport master (
    output mw_we, mw_link, mw_rd, mw_data,
    output md_issue, md_issue_rd, md_valid, md_rd, md_data,
    output fd_rs_a, fd_rs_b, fd_rd,
    input  md_ready, busy_a, busy_b, busy_d,
    input  rf_we, rf_waddr, rf_wdata, proto_err
  );

  modport slave (
    input  mw_we, mw_link, mw_rd, mw_data,
    input  md_issue, md_issue_rd, md_valid, md_rd, md_data,
    input  fd_rs_a, fd_rs_b, fd_rd,
    output md_ready, busy_a, busy_b, busy_d,
    output rf_we, rf_waddr, rf_wdata, proto_err
  );

endinterface

// File: rtl/regfile_writeback_arbiter_wb_pending_fifo.sv
// Small FIFO holding mult/div results that lost write-port arbitration.
// Latency: head is combinational from the read pointer; a push is visible at head the next cycle.
// Backpressure: full/empty flags; push is ignored when full unless a pop frees the slot.
// Ports: clock, reset_n, push/din, pop, full, empty, head.
module wb_pending_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_pop;
  logic         do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port owner: merges MW writebacks with mult/div results and tracks busy registers.
// Latency: 1 cycle from winning source to rf_*; busy_* and md_ready are combinational.
// Backpressure: MW never stalls; mult/div results queue in a FIFO, md_ready = FIFO not full.
// Ports: clock, reset_n (async active-low), bus (slave modport of regfile_writeback_arbiter_if).
module regfile_writeback_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int QDEPTH   = 4,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input logic                        clock,
  input logic                        reset_n,
  regfile_writeback_arbiter_if.slave bus
);
  localparam int REG_AW = reg_aw(NREGS);
  localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } md_ent_t;

  md_ent_t           q_din;
  md_ent_t           q_head;
  logic              q_full;
  logic              q_empty;
  logic              q_push;
  logic              q_pop;
  logic              md_xfer;

  wb_src_e           src;
  logic [REG_AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_we;

  logic              rf_we_q;
  logic              rf_md_q;
  logic [REG_AW-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              proto_err_q;

  logic [NREGS-1:0]  sb;
  logic [NREGS-1:0]  sb_next;

  // md_ready reflects fullness at the start of the cycle; a pop this cycle does not reopen it.
  assign md_xfer      = bus.md_valid && !q_full;
  assign bus.md_ready = !q_full;

  // Priority: MW, then queued results (oldest first), then a direct bypass of the incoming result.
  always_comb begin
    src     = WB_NONE;
    wr_addr = '0;
    wr_data = '0;
    q_pop   = 1'b0;
    if (bus.mw_we) begin
      src     = WB_MW;
      wr_addr = bus.mw_link ? LINK_ADDR : bus.mw_rd;
      wr_data = bus.mw_data;
    end else if (!q_empty) begin
      src     = WB_MD_Q;
      wr_addr = q_head.rd;
      wr_data = q_head.data;
      q_pop   = 1'b1;
    end else if (md_xfer) begin
      src     = WB_MD_BYP;
      wr_addr = bus.md_rd;
      wr_data = bus.md_data;
    end
  end

  // Writes to r0 are swallowed here, after the source (and its FIFO slot) has been consumed.
  assign wr_we      = (src != WB_NONE) && (wr_addr != '0);
  assign q_push     = md_xfer && (src != WB_MD_BYP);
  assign q_din.rd   = bus.md_rd;
  assign q_din.data = bus.md_data;

  wb_pending_fifo #(
    .W     (DATA_W + REG_AW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (q_push),
    .din     (q_din),
    .pop     (q_pop),
    .full    (q_full),
    .empty   (q_empty),
    .head    (q_head)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_q     <= 1'b0;
      rf_md_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rf_we_q <= wr_we;
      rf_md_q <= wr_we && ((src == WB_MD_Q) || (src == WB_MD_BYP));
      if (src != WB_NONE) begin
        rf_waddr_q <= wr_addr;
        rf_wdata_q <= wr_data;
      end
      if (bus.md_valid && q_full) proto_err_q <= 1'b1;
    end
  end

  // Clear follows the registered write; a same-cycle issue to that register re-arms it.
  always_comb begin
    sb_next = sb;
    if (rf_md_q)      sb_next[rf_waddr_q]      = 1'b0;
    if (bus.md_issue) sb_next[bus.md_issue_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sb <= '0;
    else          sb <= sb_next;
  end

  assign bus.busy_a    = sb[bus.fd_rs_a];
  assign bus.busy_b    = sb[bus.fd_rs_b];
  assign bus.busy_d    = sb[bus.fd_rd];
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; registered outputs are checked there too,
// combinational outputs 1 unit after the inputs settle.
module tb_regfile_writeback_arbiter;
  logic clock;
  logic reset_n;
  int   errors;
  int   checks;

  regfile_writeback_arbiter_if #(.DATA_W(32), .NREGS(32)) bus ();

  regfile_writeback_arbiter #(
    .DATA_W   (32),
    .NREGS    (32),
    .QDEPTH   (4),
    .LINK_REG (31)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_we"},    32'(bus.rf_we),    32'd1);
    chk({tag, "_waddr"}, 32'(bus.rf_waddr), addr);
    chk({tag, "_wdata"}, bus.rf_wdata,      data);
  endtask

  task automatic idle();
    bus.mw_we    = 1'b0;
    bus.mw_link  = 1'b0;
    bus.md_issue = 1'b0;
    bus.md_valid = 1'b0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    idle();
    bus.mw_rd = '0;       bus.mw_data = '0;
    bus.md_issue_rd = '0; bus.md_rd = '0;  bus.md_data = '0;
    bus.fd_rs_a = '0;     bus.fd_rs_b = '0; bus.fd_rd = '0;

    // Reset state
    tick(); tick();
    chk("rst_rf_we",     32'(bus.rf_we),     32'd0);
    chk("rst_rf_waddr",  32'(bus.rf_waddr),  32'd0);
    chk("rst_rf_wdata",  bus.rf_wdata,       32'd0);
    chk("rst_proto_err", 32'(bus.proto_err), 32'd0);
    chk("rst_md_ready",  32'(bus.md_ready),  32'd1);
    reset_n = 1'b1;
    tick();

    // MW write, then link write forced to r31
    bus.mw_we = 1'b1; bus.mw_rd = 5'd5; bus.mw_data = 32'hA5;
    tick();
    chk_rf("mw", 32'd5, 32'hA5);
    bus.mw_link = 1'b1;
    tick();
    chk_rf("link", 32'd31, 32'hA5);
    idle();
    tick();
    chk("mw_idle_we", 32'(bus.rf_we), 32'd0);

    // Issue marks r7 busy; bypass result writes and then clears it
    bus.md_issue = 1'b1; bus.md_issue_rd = 5'd7; bus.fd_rs_a = 5'd7;
    settle();
    chk("sb7_before", 32'(bus.busy_a), 32'd0);
    tick();
    bus.md_issue = 1'b0;
    settle();
    chk("sb7_busy_a", 32'(bus.busy_a), 32'd1);
    chk("sb7_busy_b", 32'(bus.busy_b), 32'd0);
    bus.md_valid = 1'b1; bus.md_rd = 5'd7; bus.md_data = 32'h1234;
    settle();
    chk("byp_ready", 32'(bus.md_ready), 32'd1);
    tick();
    bus.md_valid = 1'b0;
    chk_rf("byp", 32'd7, 32'h1234);
    chk("sb7_during_wr", 32'(bus.busy_a), 32'd1);
    tick();
    chk("sb7_cleared", 32'(bus.busy_a), 32'd0);
    chk("byp_after_we", 32'(bus.rf_we), 32'd0);
    bus.fd_rs_a = '0;

    // MW holds the port 6 cycles; 4 md results queue, source waits with the 5th
    for (int k = 0; k < 6; k++) begin
      bus.mw_we = 1'b1; bus.mw_rd = 5'(10 + k); bus.mw_data = 32'(32'h300 + k);
      if (k < 4) begin
        bus.md_valid = 1'b1; bus.md_rd = 5'(k + 1); bus.md_data = 32'(32'h100 + k + 1);
      end else begin
        bus.md_valid = 1'b0;
      end
      settle();
      chk($sformatf("fill_ready_%0d", k), 32'(bus.md_ready), (k < 4) ? 32'd1 : 32'd0);
      tick();
      chk_rf($sformatf("fill_mw_%0d", k), 32'(10 + k), 32'(32'h300 + k));
    end
    idle();
    settle();
    chk("full_pop_ready", 32'(bus.md_ready), 32'd0);
    tick();
    chk_rf("drain_1", 32'd1, 32'h101);
    bus.md_valid = 1'b1; bus.md_rd = 5'd5; bus.md_data = 32'h105;
    settle();
    chk("refill_ready", 32'(bus.md_ready), 32'd1);
    tick();
    bus.md_valid = 1'b0;
    chk_rf("drain_2", 32'd2, 32'h102);
    for (int k = 3; k <= 5; k++) begin
      tick();
      chk_rf($sformatf("drain_%0d", k), 32'(k), 32'(32'h100 + k));
    end
    tick();
    chk("drain_done_we", 32'(bus.rf_we), 32'd0);
    chk("drain_proto", 32'(bus.proto_err), 32'd0);

    // Result forced while full is dropped and latches proto_err
    for (int k = 0; k < 5; k++) begin
      bus.mw_we = 1'b1; bus.mw_rd = 5'd20; bus.mw_data = 32'(32'h400 + k);
      bus.md_valid = 1'b1;
      if (k < 4) begin
        bus.md_rd = 5'(11 + k); bus.md_data = 32'(32'h200 + 11 + k);
      end else begin
        bus.md_rd = 5'd15; bus.md_data = 32'hDEAD;
      end
      settle();
      if (k == 4) chk("forced_ready", 32'(bus.md_ready), 32'd0);
      tick();
      chk_rf($sformatf("pe_mw_%0d", k), 32'd20, 32'(32'h400 + k));
    end
    idle();
    chk("pe_set", 32'(bus.proto_err), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_rf($sformatf("pe_drain_%0d", k), 32'(11 + k), 32'(32'h200 + 11 + k));
    end
    tick();
    chk("pe_no_r15", 32'(bus.rf_we), 32'd0);
    tick(); tick(); tick();
    chk("pe_sticky", 32'(bus.proto_err), 32'd1);
    chk("pe_still_idle", 32'(bus.rf_we), 32'd0);

    // r0 results: bypass and queued, both consumed without a write
    bus.md_valid = 1'b1; bus.md_rd = 5'd0; bus.md_data = 32'h77;
    tick();
    bus.md_valid = 1'b0;
    chk("r0_byp_we", 32'(bus.rf_we), 32'd0);
    bus.mw_we = 1'b1; bus.mw_rd = 5'd3; bus.mw_data = 32'h33;
    bus.md_valid = 1'b1; bus.md_rd = 5'd0; bus.md_data = 32'h78;
    tick();
    idle();
    chk_rf("r0_mw", 32'd3, 32'h33);
    tick();
    chk("r0_q_we", 32'(bus.rf_we), 32'd0);
    bus.md_valid = 1'b1; bus.md_rd = 5'd6; bus.md_data = 32'h66;
    tick();
    bus.md_valid = 1'b0;
    chk_rf("after_r0", 32'd6, 32'h66);

    // Re-issue to r9 in the cycle its queued result leaves: set wins
    bus.md_issue = 1'b1; bus.md_issue_rd = 5'd9;
    bus.mw_we = 1'b1; bus.mw_rd = 5'd2; bus.mw_data = 32'h22;
    bus.md_valid = 1'b1; bus.md_rd = 5'd9; bus.md_data = 32'h99;
    tick();
    idle();
    bus.fd_rd = 5'd9;
    settle();
    chk("sb9_busy", 32'(bus.busy_d), 32'd1);
    tick();
    chk_rf("q9", 32'd9, 32'h99);
    bus.md_issue = 1'b1; bus.md_issue_rd = 5'd9;
    tick();
    bus.md_issue = 1'b0;
    chk("sb9_set_wins", 32'(bus.busy_d), 32'd1);
    tick();
    chk("sb9_held", 32'(bus.busy_d), 32'd1);

    // Reset in the middle of a burst discards queue and scoreboard
    for (int k = 0; k < 2; k++) begin
      bus.mw_we = 1'b1; bus.mw_rd = 5'd4; bus.mw_data = 32'(32'h500 + k);
      bus.md_valid = 1'b1; bus.md_rd = 5'(12 + k); bus.md_data = 32'(32'h600 + k);
      bus.md_issue = 1'b1; bus.md_issue_rd = 5'(12 + k);
      tick();
    end
    idle();
    bus.fd_rs_a = 5'd12; bus.fd_rs_b = 5'd9; bus.fd_rd = 5'd13;
    reset_n = 1'b0;
    tick();
    chk("mid_rst_we",     32'(bus.rf_we),     32'd0);
    chk("mid_rst_busy_a", 32'(bus.busy_a),    32'd0);
    chk("mid_rst_busy_b", 32'(bus.busy_b),    32'd0);
    chk("mid_rst_busy_d", 32'(bus.busy_d),    32'd0);
    chk("mid_rst_ready",  32'(bus.md_ready),  32'd1);
    chk("mid_rst_proto",  32'(bus.proto_err), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_we_0", 32'(bus.rf_we), 32'd0);
    tick();
    chk("post_rst_we_1", 32'(bus.rf_we), 32'd0);
    chk("post_rst_ready", 32'(bus.md_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
